data_mem_wb: RTL

- MEM stage of the 5-stage ARM-subset pipeline. It sits directly downstream of the EX/MEM register and consumes its MEM_* control bits together with the ALU result, store data and destination register.
- Contains the 256-byte big-endian data RAM for LDR/STR/LDRB/STRB, with byte order matching the instruction ROM.
- Registers the write-back payload (data, Rd, RF enable) for the register file. One cycle of latency into WB.

---
 rtl/data_mem_wb_pkg.sv | 13 +
 rtl/data_mem_wb_ram.sv | 68 ++++++
 rtl/data_mem_wb.sv | 72 +++++++
 3 files changed

// File: rtl/data_mem_wb_pkg.sv
// Shared definitions for the MEM stage and its data RAM.
//   ADDR_W    : byte-address width of the data RAM
//   DEPTH     : RAM size in bytes
//   DATA_W    : machine word width
//   SIZE_BYTE / SIZE_WORD : encodings of MEM_Size_enable
package data_mem_wb_pkg;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int DATA_W = 32;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
endpackage

// File: rtl/data_mem_wb_ram.sv
// Big-endian byte-addressed data RAM.
// Ports:
//   clk      : rising-edge clock
//   we       : store strobe (already qualified by reset and enable)
//   size     : SIZE_WORD or SIZE_BYTE
//   addr     : byte address (word-aligned by the caller for word accesses)
//   wdata    : store data; byte stores take wdata[7:0]
//   rd_en    : read valid; rdata is zero otherwise
//   rdata    : combinational read data (bytes zero-extended)
//   dbg_addr : peek address, any alignment, wraps mod DEPTH
//   dbg_word : combinational big-endian word starting at dbg_addr
module data_ram
    import data_mem_wb_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic              size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_word
);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] THREE = ADDR_W'(3);

    // No reset: contents survive a pipeline reset.
    logic [7:0] mem [0:DEPTH-1];

    logic [ADDR_W-1:0] addr1, addr2, addr3;
    logic [ADDR_W-1:0] dbg1, dbg2, dbg3;

    // Word addresses are aligned, so addr+3 never wraps; the debug port may wrap.
    assign addr1 = addr + ONE;
    assign addr2 = addr + TWO;
    assign addr3 = addr + THREE;
    assign dbg1  = dbg_addr + ONE;
    assign dbg2  = dbg_addr + TWO;
    assign dbg3  = dbg_addr + THREE;

    always_ff @(posedge clk) begin
        if (we) begin
            if (size == SIZE_WORD) begin
                mem[addr]  <= wdata[31:24];
                mem[addr1] <= wdata[23:16];
                mem[addr2] <= wdata[15:8];
                mem[addr3] <= wdata[7:0];
            end else begin
                mem[addr]  <= wdata[7:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (size == SIZE_WORD) begin
                rdata = {mem[addr], mem[addr1], mem[addr2], mem[addr3]};
            end else begin
                rdata = {24'b0, mem[addr]};
            end
        end
    end

    assign dbg_word = {mem[dbg_addr], mem[dbg1], mem[dbg2], mem[dbg3]};
endmodule

// File: rtl/data_mem_wb.sv
// MEM stage: data RAM access, load/ALU result select and the MEM/WB register.
// Ports:
//   clk, R            : clock and synchronous active-low reset
//   MEM_* inputs      : EX/MEM control bits, ALU result, store data, Rd
//   WB_data/Rd/RF_enable/misalign : registered write-back payload
//   mem_fwd_data      : combinational MEM-stage result for forwarding
//   dbg_addr/dbg_word : RAM peek port
module data_mem_wb
    import data_mem_wb_pkg::*;
(
    input  logic              clk,
    input  logic              R,
    input  logic              MEM_load_instr,
    input  logic              MEM_RF_enable,
    input  logic              MEM_Size_enable,
    input  logic              MEM_RW_enable,
    input  logic              MEM_Enable_signal,
    input  logic [DATA_W-1:0] MEM_alu_out,
    input  logic [DATA_W-1:0] MEM_store_data,
    input  logic [3:0]        MEM_Rd,
    output logic [DATA_W-1:0] WB_data,
    output logic [3:0]        WB_Rd,
    output logic              WB_RF_enable,
    output logic              WB_misalign,
    output logic [DATA_W-1:0] mem_fwd_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_word
);
    logic [ADDR_W-1:0] addr_raw;
    logic [ADDR_W-1:0] addr_eff;
    logic              store;
    logic              rd_en;
    logic              load_sel;
    logic [DATA_W-1:0] rd_data;

    assign addr_raw = MEM_alu_out[ADDR_W-1:0];
    // Misaligned word accesses are carried out at the aligned address.
    assign addr_eff = (MEM_Size_enable == SIZE_WORD) ? {addr_raw[ADDR_W-1:2], 2'b00}
                                                     : addr_raw;
    assign store    = MEM_Enable_signal & MEM_RW_enable;
    assign rd_en    = MEM_Enable_signal & ~MEM_RW_enable;
    assign load_sel = MEM_load_instr & rd_en;

    data_ram u_ram (
        .clk      (clk),
        .we       (store & R),
        .size     (MEM_Size_enable),
        .addr     (addr_eff),
        .wdata    (MEM_store_data),
        .rd_en    (rd_en),
        .rdata    (rd_data),
        .dbg_addr (dbg_addr),
        .dbg_word (dbg_word)
    );

    assign mem_fwd_data = load_sel ? rd_data : MEM_alu_out;

    always_ff @(posedge clk) begin
        if (!R) begin
            WB_data      <= '0;
            WB_Rd        <= '0;
            WB_RF_enable <= 1'b0;
            WB_misalign  <= 1'b0;
        end else begin
            WB_data      <= mem_fwd_data;
            WB_Rd        <= MEM_Rd;
            WB_RF_enable <= MEM_RF_enable & ~store;
            WB_misalign  <= MEM_Enable_signal & (MEM_Size_enable == SIZE_WORD)
                            & (addr_raw[1:0] != 2'b00);
        end
    end
endmodule
